approx_wide_add_sched: RTL and testbench
========================================

Name: approx_wide_add_sched

Overview:
- Shares one `ripple_carry_adder7` instance (N-bit approximate ripple-carry adder) between two requesters.
- Each request is a W-bit add (W = N*K). The block sequences it as K chunk additions, one chunk per cycle, least-significant chunk first.
- The Cout of each chunk is registered and fed back as the Cin of the next chunk.
- It sits between the approximate-multiplier partial-product stages and the shared adder datapath.

Parameters:
- N, 8, width of the shared `ripple_carry_adder7` slice in bits.
- K, 4, number of chunks per request; W = N*K; K >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_a, req0_b  input  W  requester 0 operands.
- req0_cin  input  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0, for requester 1.
- res_valid  output  1  result available.
- res_ready  input  1  consumer takes the result.
- res_sum  output  W  approximate sum.
- res_cout  output  1  carry out of the last chunk.
- res_id  output  1  index of the requester that owns the result.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: asynchronous clear while rst_n = 0, regardless of clk.
  - State = IDLE; rr_last = 1 (requester 0 wins first).
  - res_valid, res_sum, res_cout, res_id, busy, both req*_ready = 0.
  - Operand, chunk-index and carry registers = 0.
- Reset mid-operation: the in-flight request and any held result are discarded; no response is ever produced for them.
- States: IDLE, RUN, DONE.
- IDLE:
  - req*_ready is combinational and asserted only in IDLE, only for the granted requester.
  - Round-robin grant: if both are valid, grant the requester != rr_last; otherwise grant the single valid one.
  - On handshake (valid & ready): latch a, b, cin and id; set rr_last = id; chunk index = 0; go to RUN.
- RUN, chunk i = 0..K-1:
  - Shared adder inputs: A = a[i*N +: N], B = b[i*N +: N], Cin = cin (i = 0) or the registered carry (i > 0).
  - Each cycle: register Sum into sum[i*N +: N] and Cout into the carry register; increment i.
  - After i = K-1, go to DONE.
- DONE:
  - res_valid = 1; res_sum, res_cout and res_id are registered and stable until the handshake.
  - On res_valid & res_ready: go to IDLE, clear res_valid.
  - No same-cycle bypass: a new request is accepted at the earliest on the cycle after DONE exits.
- Latency: request accepted at edge t → res_valid high after edge t+K. A requester is ready at most once every K+2 cycles.
- Backpressure:
  - res_ready low holds DONE indefinitely; both ready outputs stay low.
  - Requesters must hold valid and data stable until ready.
- A request arriving in RUN or DONE waits; its req*_ready stays 0.
- Arithmetic: all widths are exact.
  - Sum chunks are not truncated or extended.
  - res_cout is the Cout of chunk K-1.
  - Result equals a chained bit-level model of approximate_adder7 across all W bits, starting from cin.
- K = 1: exactly one RUN cycle.

Optional Feature:
- Macro: APPROX_WIDE_ADD_STATS_EN.
- Defined:
  - Adds output port op_count (32 bits), reset to 0.
  - Increments on every result handshake and wraps 0xFFFFFFFF → 0.
  - Adds output port stall_count (32 bits), reset to 0. It increments each cycle in DONE with res_ready = 0, saturating at 0xFFFFFFFF.
- Undefined: neither port exists; all other behaviour is identical.

Decomposition:
- Shared include approx_add_pkg.vh:
  - State encoding localparams ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2.
  - Counter width localparam CNT_W = 32.
  - A clog2-style macro for chunk-index width, minimum 1 bit.
- One sub-module: the existing `ripple_carry_adder7 #(.N(N))`, instantiated once.
- The round-robin grant stays inline; it is too small for its own module.

Test Plan:
- Single request: N=8, K=4. req0 a=0x0000_0001, b=0x0000_0001, cin=0.
  - Required: req0_ready high in the accept cycle; res_valid exactly 4 edges later; res_id=0.
  - res_sum/res_cout match the chained approximate_adder7 model.
- Carry chain: a=0x00FF_FFFF, b=0x0000_0001, cin=0.
  - Required: the carry register propagates across chunk boundaries.
  - Result equals the model, not exact addition.
- Simultaneous requests: both valid for 3 ops after reset.
  - Required grant order 0, 1, 0; res_id sequence matches; requester stimulus held stable while waiting.
- Backpressure: res_ready = 0 for 10 cycles in DONE.
  - Required: res_* stable; both ready outputs 0; busy = 1; with APPROX_WIDE_ADD_STATS_EN, stall_count = 10.
  - Then res_ready = 1 → IDLE next cycle; new request accepted the following cycle.
- Reset mid-RUN: drop rst_n at chunk 2.
  - Required: all outputs 0 immediately (asynchronous); no result appears after release.
  - Next grant goes to requester 0.
- Config: K=1, N=8, a=0xFF, b=0x01, cin=1 → one RUN cycle; res_valid 1 edge after accept; result matches the model.

Source files
------------

// File: rtl/approx_wide_add_sched_pkg.sv
// Shared types and constants for the chunked approximate wide-add scheduler.
package approx_wide_add_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int CNT_W = 32;

    // Width of a chunk index for k chunks; never narrower than one bit.
    function automatic int idx_w(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/approx_wide_add_sched_rca7.sv
// Approximate full-adder cell and the N-bit ripple-carry slice built from it.
// Cell: carry is the exact majority; sum is ~carry except when all three inputs are 1.
module approximate_adder7 (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    always_comb begin
        Cout = (A & B) | (Cin & (A | B));
        Sum  = ~Cout | (A & B & Cin);
    end

endmodule

module ripple_carry_adder7 #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    logic [N:0] carry;

    assign carry[0] = Cin;
    assign Cout     = carry[N];

    for (genvar i = 0; i < N; i++) begin : g_bit
        approximate_adder7 u_cell (
            .A   (A[i]),
            .B   (B[i]),
            .Cin (carry[i]),
            .Sum (Sum[i]),
            .Cout(carry[i+1])
        );
    end

endmodule

// File: rtl/approx_wide_add_sched.sv
// Two-requester scheduler sequencing W-bit approximate adds over one shared N-bit adder.
// Optional statistics counters are enabled with `define APPROX_WIDE_ADD_STATS_EN.
module approx_wide_add_sched
    import approx_wide_add_sched_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [N*K-1:0]   req0_a,
    input  logic [N*K-1:0]   req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [N*K-1:0]   req1_a,
    input  logic [N*K-1:0]   req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N*K-1:0]   res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic             busy
`ifdef APPROX_WIDE_ADD_STATS_EN
    ,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] stall_count
`endif
);

    localparam int W  = N * K;
    localparam int IW = idx_w(K);
    localparam logic [IW-1:0] LAST = IW'(K - 1);

    state_e          state_q, state_d;
    logic            rr_last_q, rr_last_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            id_q, id_d;

    logic            grant0, grant1;
    logic [31:0]     base;
    logic [N-1:0]    add_a, add_b, add_sum;
    logic            add_cout;

    always_comb begin
        grant1 = req1_valid & (~req0_valid | ~rr_last_q);
        grant0 = req0_valid & ~grant1;
    end

    always_comb begin
        base  = 32'(idx_q) * N;
        add_a = a_q[base +: N];
        add_b = b_q[base +: N];
    end

    // Carry register is seeded with the request's cin on accept, so chunk 0
    // needs no separate cin mux.
    ripple_carry_adder7 #(.N(N)) u_adder (
        .A   (add_a),
        .B   (add_b),
        .Cin (carry_q),
        .Sum (add_sum),
        .Cout(add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_last_q <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            id_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            id_q      <= id_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        id_d      = id_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0 | grant1) begin
                    id_d      = grant1;
                    rr_last_d = grant1;
                    a_d       = grant1 ? req1_a   : req0_a;
                    b_d       = grant1 ? req1_b   : req0_b;
                    carry_d   = grant1 ? req1_cin : req0_cin;
                    idx_d     = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[base +: N] = add_sum;
                carry_d          = add_cout;
                idx_d            = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && (state_q == ST_IDLE)) begin
            req0_ready = grant0;
            req1_ready = grant1;
        end
        res_valid = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        res_sum   = sum_q;
        res_cout  = carry_q;
        res_id    = id_q;
    end

`ifdef APPROX_WIDE_ADD_STATS_EN
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        op_cnt_d    = op_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == ST_DONE) begin
            if (res_ready) begin
                op_cnt_d = op_cnt_q + 1'b1;
            end else if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            op_cnt_q    <= op_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign op_count    = op_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_approx_wide_add_sched.sv
// Self-checking bench for approx_wide_add_sched (K=4 main instance, K=1 side instance).
module tb_approx_wide_add_sched;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req0_valid, req0_ready, req0_cin;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_cin;
    logic [31:0] req1_a, req1_b;
    logic        res_valid, res_ready, res_cout, res_id, busy;
    logic [31:0] res_sum;

    logic        k_req0_valid, k_req0_ready, k_req0_cin;
    logic [7:0]  k_req0_a, k_req0_b;
    logic        k_req1_valid, k_req1_ready, k_req1_cin;
    logic [7:0]  k_req1_a, k_req1_b;
    logic        k_res_valid, k_res_ready, k_res_cout, k_res_id, k_busy;
    logic [7:0]  k_res_sum;

`ifdef APPROX_WIDE_ADD_STATS_EN
    logic [31:0] op_count, stall_count, k_op_count, k_stall_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int ops_done = 0;

    always #5 clk = ~clk;

    approx_wide_add_sched #(.N(8), .K(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_cout(res_cout),
        .res_id(res_id), .busy(busy)
`ifdef APPROX_WIDE_ADD_STATS_EN
        , .op_count(op_count), .stall_count(stall_count)
`endif
    );

    approx_wide_add_sched #(.N(8), .K(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(k_req0_valid), .req0_ready(k_req0_ready), .req0_a(k_req0_a), .req0_b(k_req0_b), .req0_cin(k_req0_cin),
        .req1_valid(k_req1_valid), .req1_ready(k_req1_ready), .req1_a(k_req1_a), .req1_b(k_req1_b), .req1_cin(k_req1_cin),
        .res_valid(k_res_valid), .res_ready(k_res_ready), .res_sum(k_res_sum), .res_cout(k_res_cout),
        .res_id(k_res_id), .busy(k_busy)
`ifdef APPROX_WIDE_ADD_STATS_EN
        , .op_count(k_op_count), .stall_count(k_stall_count)
`endif
    );

    // Reference: per bit, carry out when at least two inputs are 1; the sum
    // bit is 0 only when exactly two inputs are 1.
    function automatic logic [32:0] model(input int nb, input logic [31:0] a, input logic [31:0] b, input logic cin);
        logic        c;
        logic [31:0] s;
        int          ones;
        c = cin;
        s = '0;
        for (int i = 0; i < nb; i++) begin
            ones = int'(a[i]) + int'(b[i]) + int'(c);
            s[i] = (ones != 2);
            c    = (ones >= 2);
        end
        return {c, s};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts just after the accept edge; waits for the result, checks it, then consumes it.
    task automatic finish_op(input logic exp_id, input logic [31:0] es, input logic ec,
                             input int stall, input string nm);
        int lat;
        lat = 0;
        while (lat < 40 && res_valid !== 1'b1) begin
            tick();
            lat++;
        end
        chk({nm, "_lat"}, lat, 4);
        chk({nm, "_id"}, res_id, exp_id);
        chk({nm, "_sum"}, res_sum, es);
        chk({nm, "_cout"}, res_cout, ec);
        chk({nm, "_busy"}, busy, 1);
        repeat (stall) tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        ops_done++;
        chk({nm, "_rel"}, {res_valid, busy}, 2'b00);
    endtask

    task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic [31:0] es, input logic ec, input int stall, input string nm);
        int w;
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end
        #1;
        w = 0;
        while (w < 20 && !(id != 0 ? req1_ready : req0_ready)) begin
            tick();
            #1;
            w++;
        end
        chk({nm, "_rdy"}, (id != 0) ? req1_ready : req0_ready, 1);
        tick();
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
        finish_op(id[0], es, ec, stall, nm);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        int          id;
        logic [31:0] sum;
        logic        cout;
    } vec_t;

    vec_t        tbl[6];
    logic [32:0] m;
    logic [31:0] held_sum;
    logic        held_cout;
    int          w;
    int          bad;
`ifdef APPROX_WIDE_ADD_STATS_EN
    logic [31:0] stall0;
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 0, 32'hFFFF_FFFE, 1'b0};
        tbl[1] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1, 32'hFF00_0000, 1'b0};
        tbl[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, 32'hFFFF_FFFF, 1'b1};
        tbl[3] = '{32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0, 1, 32'hFEFE_FEFE, 1'b0};
        tbl[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 0, 32'hFFFF_FFFF, 1'b0};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1, 32'h7FFF_FFFF, 1'b1};

        rst_n = 1'b0;
        req0_valid = 0; req0_a = '0; req0_b = '0; req0_cin = 0;
        req1_valid = 0; req1_a = '0; req1_b = '0; req1_cin = 0;
        res_ready = 0;
        k_req0_valid = 0; k_req0_a = '0; k_req0_b = '0; k_req0_cin = 0;
        k_req1_valid = 0; k_req1_a = '0; k_req1_b = '0; k_req1_cin = 0;
        k_res_ready = 0;

        // Reset state, sampled before any clock edge.
        #3;
        req0_valid = 1'b1;
        #1;
        chk("rst_outputs", {res_valid, res_cout, res_id, busy, req0_ready, req1_ready}, '0);
        chk("rst_sum", res_sum, 0);
        chk("rst_k1_outputs", {k_res_valid, k_busy, k_res_sum}, '0);
`ifdef APPROX_WIDE_ADD_STATS_EN
        chk("rst_counters", {op_count, stall_count}, '0);
`endif
        req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Both requesters valid: grants must alternate 0, 1, 0.
        req0_a = 32'h1234_5678; req0_b = 32'h0F0F_00FF; req0_cin = 1'b0;
        req1_a = 32'hDEAD_BEEF; req1_b = 32'h0101_0101; req1_cin = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int op = 0; op < 3; op++) begin
            logic expg;
            expg = (op == 1);
            #1;
            w = 0;
            while (w < 20 && !(req0_ready | req1_ready)) begin
                tick();
                #1;
                w++;
            end
            chk("sim_grant", {req0_ready, req1_ready}, {~expg, expg});
            tick();
            if (op == 2) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end else begin
                chk("sim_wait_rdy", {req0_ready, req1_ready}, 2'b00);
            end
            m = expg ? model(32, req1_a, req1_b, req1_cin) : model(32, req0_a, req0_b, req0_cin);
            finish_op(expg, m[31:0], m[32], 0, "sim");
        end

        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, 0, "tbl");
        end

        // Backpressure: hold DONE for 10 cycles with requester 1 waiting.
        req0_valid = 1'b1; req0_a = 32'hCAFE_F00D; req0_b = 32'h1357_9BDF; req0_cin = 1'b1;
        #1;
        w = 0;
        while (w < 20 && !req0_ready) begin
            tick();
            #1;
            w++;
        end
        chk("bp_rdy", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'h0000_FFFF; req1_b = 32'h0000_0001; req1_cin = 1'b0;
        w = 0;
        while (w < 40 && res_valid !== 1'b1) begin
            tick();
            w++;
        end
        m = model(32, 32'hCAFE_F00D, 32'h1357_9BDF, 1'b1);
        chk("bp_result", {res_cout, res_sum, res_id}, {m[32], m[31:0], 1'b0});
        held_sum  = res_sum;
        held_cout = res_cout;
`ifdef APPROX_WIDE_ADD_STATS_EN
        stall0 = stall_count;
`endif
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (res_valid !== 1'b1 || res_sum !== held_sum || res_cout !== held_cout ||
                res_id !== 1'b0 || busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
                bad++;
        end
        chk("bp_hold_cycles_bad", bad, 0);
`ifdef APPROX_WIDE_ADD_STATS_EN
        chk("bp_stall_count", stall_count - stall0, 10);
`endif
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        ops_done++;
        chk("bp_idle", {res_valid, busy}, 2'b00);
        #1;
        chk("bp_next_rdy", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        chk("bp_next_busy", busy, 1);
        m = model(32, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
        finish_op(1'b1, m[31:0], m[32], 0, "bp_next");

        for (int r = 0; r < 20; r++) begin
            logic [31:0] ra, rb;
            logic        rc;
            int          rid;
            rid = $urandom_range(0, 1);
            ra  = $urandom;
            rb  = $urandom;
            rc  = 1'($urandom_range(0, 1));
            m   = model(32, ra, rb, rc);
            do_op(rid, ra, rb, rc, m[31:0], m[32], $urandom_range(0, 3), "rnd");
        end

`ifdef APPROX_WIDE_ADD_STATS_EN
        chk("op_count", op_count, ops_done);
`endif

        // Reset while chunk 2 is in flight: nothing may come out afterwards.
        req1_valid = 1'b1; req1_a = 32'h00FF_FFFF; req1_b = 32'h0000_0001; req1_cin = 1'b0;
        #1;
        w = 0;
        while (w < 20 && !req1_ready) begin
            tick();
            #1;
            w++;
        end
        chk("mrst_rdy", req1_ready, 1);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_async", {res_valid, busy, res_id, res_cout, req0_ready, req1_ready}, '0);
        chk("mrst_sum", res_sum, 0);
        tick();
        chk("mrst_held", {res_valid, busy, req1_ready}, '0);
        req1_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        chk("mrst_no_result", bad, 0);
        req0_valid = 1'b1; req0_a = 32'h0000_0001; req0_b = 32'h0000_0001; req0_cin = 1'b0;
        req1_valid = 1'b1;
        #1;
        chk("mrst_grant0", {req0_ready, req1_ready}, 2'b10);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        finish_op(1'b0, 32'hFFFF_FFFE, 1'b0, 0, "mrst_op");

        // K=1 instance: one RUN cycle, result one edge after accept.
        k_req0_valid = 1'b1; k_req0_a = 8'hFF; k_req0_b = 8'h01; k_req0_cin = 1'b1;
        #1;
        chk("k1_rdy", k_req0_ready, 1);
        tick();
        k_req0_valid = 1'b0;
        chk("k1_run", {k_res_valid, k_busy}, 2'b01);
        tick();
        chk("k1_valid", k_res_valid, 1);
        chk("k1_result", {k_res_cout, k_res_sum, k_res_id}, {1'b1, 8'h01, 1'b0});
        m = model(8, 32'h0000_00FF, 32'h0000_0001, 1'b1);
        chk("k1_model", {k_res_cout, k_res_sum}, {m[32], m[7:0]});
        k_res_ready = 1'b1;
        tick();
        k_res_ready = 1'b0;
        chk("k1_rel", {k_res_valid, k_busy}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
